// File: rtl/time_set_controller_pkg.sv
// Shared encodings and field limits for the clock time base.
// No logic: constants and the mode enum only.
// Not applicable: no datapath or flow control here.
package time_set_controller_pkg;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'b00,
        MODE_SET_H = 2'b01,
        MODE_SET_M = 2'b10
    } mode_t;

    localparam int HOURS_MAX  = 23;
    localparam int MINSEC_MAX = 59;
    localparam int HOURS_W    = 5;
    localparam int MINSEC_W   = 6;

endpackage

// File: rtl/time_set_controller_wrap_counter.sv
// Modulo-(MAX+1) up counter with synchronous clear and combinational carry-out.
// Value updates on the edge that samples inc/clr; carry is same-cycle.
// No backpressure: inc is a single-cycle strobe, clr has priority over inc.
module wrap_counter #(
    parameter int MAX = 59,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic         carry
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    assign carry = inc && (value == MAX_V);

    // Count with wrap at MAX; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            value <= (value == MAX_V) ? '0 : value + 1'b1;
        end
    end

endmodule

// File: rtl/time_set_controller.sv
// Clock time base: 1 s prescaler, hh:mm:ss counters, RUN/SET_H/SET_M mode FSM with auto-repeat.
// Outputs registered; button edges act on the edge that samples them (1 cycle latency).
// No backpressure: button levels are sampled every cycle, nothing is ever stalled.
module time_set_controller
    import time_set_controller_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int HOLD_DIV = 12_500_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                btn_mode,
    input  logic                btn_up,
    output logic [HOURS_W-1:0]  hours,
    output logic [MINSEC_W-1:0] minutes,
    output logic [MINSEC_W-1:0] seconds,
    output logic [1:0]          mode,
    output logic                blink
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = (HOLD_DIV > 1) ? $clog2(HOLD_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] BLINK_MAX = PW'(TICK_DIV / 2 - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_DIV - 1);

    mode_t         state_q;
    mode_t         state_d;
    logic          btn_mode_q;
    logic          btn_up_q;
    logic          rise_mode;
    logic          rise_up;
    logic          mode_chg;
    logic          up_step;
    logic          tick;
    logic          set_h_inc;
    logic          set_m_inc;
    logic          sec_clr;
    logic          sec_carry;
    logic          min_carry;
    logic          hr_carry_unused;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] blink_cnt_q;
    logic [HW-1:0] hold_q;

    assign rise_mode = btn_mode & ~btn_mode_q;
    assign rise_up   = btn_up & ~btn_up_q;
    assign mode      = state_q;

    // Previous-cycle button samples for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_mode_q <= 1'b0;
            btn_up_q   <= 1'b0;
        end else begin
            btn_mode_q <= btn_mode;
            btn_up_q   <= btn_up;
        end
    end

    // Mode state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MODE_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next mode and per-cycle strobes; a mode change suppresses any field increment
    always_comb begin
        state_d   = state_q;
        mode_chg  = 1'b0;
        up_step   = 1'b0;
        tick      = 1'b0;
        set_h_inc = 1'b0;
        set_m_inc = 1'b0;
        sec_clr   = 1'b0;
        case (state_q)
            MODE_RUN:   if (rise_mode) state_d = MODE_SET_H;
            MODE_SET_H: if (rise_mode) state_d = MODE_SET_M;
            MODE_SET_M: if (rise_mode) state_d = MODE_RUN;
            default:    state_d = MODE_RUN;
        endcase
        mode_chg  = (state_d != state_q);
        up_step   = rise_up || (btn_up && btn_up_q && (hold_q == HOLD_MAX));
        tick      = (state_q == MODE_RUN) && (presc_q == PRESC_MAX);
        set_h_inc = (state_q == MODE_SET_H) && !mode_chg && up_step;
        set_m_inc = (state_q == MODE_SET_M) && !mode_chg && up_step;
        sec_clr   = (state_q == MODE_SET_M) && (state_d == MODE_RUN);
    end

    // 1 s prescaler: only runs while staying in RUN, so re-entry restarts a full period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if ((state_q == MODE_RUN) && (state_d == MODE_RUN)) begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
        end else begin
            presc_q <= '0;
        end
    end

    // Auto-repeat timer: restarts on the press edge, runs while held, cleared on release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else if (mode_chg || !btn_up || rise_up || (hold_q == HOLD_MAX)) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_q + 1'b1;
        end
    end

    // Blink for the field being set: on at SET entry, toggles every TICK_DIV/2 cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink       <= 1'b0;
            blink_cnt_q <= '0;
        end else if (state_d == MODE_RUN) begin
            blink       <= 1'b0;
            blink_cnt_q <= '0;
        end else if (mode_chg) begin
            blink       <= 1'b1;
            blink_cnt_q <= '0;
        end else if (blink_cnt_q == BLINK_MAX) begin
            blink       <= ~blink;
            blink_cnt_q <= '0;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    wrap_counter #(.MAX(MINSEC_MAX), .W(MINSEC_W)) u_sec (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (tick),
        .clr   (sec_clr),
        .value (seconds),
        .carry (sec_carry)
    );

    // Set-mode minute increments may wrap 59->0 but must not reach hours,
    // so the hour carry is qualified by the seconds carry.
    wrap_counter #(.MAX(MINSEC_MAX), .W(MINSEC_W)) u_min (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (sec_carry | set_m_inc),
        .clr   (1'b0),
        .value (minutes),
        .carry (min_carry)
    );

    wrap_counter #(.MAX(HOURS_MAX), .W(HOURS_W)) u_hr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   ((sec_carry & min_carry) | set_h_inc),
        .clr   (1'b0),
        .value (hours),
        .carry (hr_carry_unused)
    );

endmodule

// File: tb/tb_time_set_controller.sv
module tb_time_set_controller;

    localparam int TICK_DIV = 4;
    localparam int HOLD_DIV = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_mode;
    logic       btn_up;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] mode;
    logic       blink;

    int errors = 0;
    int checks = 0;

    // Reference model: time of day in seconds, mode 0/1/2, cycles into the
    // current second while running, and cycles since entering a set mode.
    int tod;
    int mmode;
    int phase;
    int age;

    time_set_controller #(.TICK_DIV(TICK_DIV), .HOLD_DIV(HOLD_DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_mode (btn_mode),
        .btn_up   (btn_up),
        .hours    (hours),
        .minutes  (minutes),
        .seconds  (seconds),
        .mode     (mode),
        .blink    (blink)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic advance(input int n);
        if (mmode == 0) begin
            tod   = (tod + (phase + n) / TICK_DIV) % 86400;
            phase = (phase + n) % TICK_DIV;
        end else begin
            age = age + n;
        end
    endtask

    task automatic idle(input int n);
        step(n);
        advance(n);
    endtask

    task automatic bump_field(input int k);
        int h, m, s;
        h = tod / 3600;
        m = (tod / 60) % 60;
        s = tod % 60;
        if (mmode == 1) h = (h + k) % 24;
        if (mmode == 2) m = (m + k) % 60;
        tod = h * 3600 + m * 60 + s;
    endtask

    task automatic hold_up(input int n);
        btn_up = 1'b1;
        step(n);
        btn_up = 1'b0;
        if (mmode != 0) bump_field(1 + (n - 1) / HOLD_DIV);
        advance(n);
        step(1);
        advance(1);
    endtask

    task automatic press_mode(input bit with_up);
        // keep the mode edge off the cycle where a second would roll over
        if (mmode == 0 && phase == TICK_DIV - 1) idle(1);
        btn_mode = 1'b1;
        btn_up   = with_up;
        step(1);
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        case (mmode)
            0: begin mmode = 1; age = 0; end
            1: begin mmode = 2; age = 0; end
            default: begin
                tod   = tod - (tod % 60);
                phase = 0;
                mmode = 0;
            end
        endcase
        step(1);
        advance(1);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int exp_blink;
        exp_blink = (mmode == 0) ? 0 : (((age / (TICK_DIV / 2)) % 2 == 0) ? 1 : 0);
        chk({tag, " hours"},   32'(hours),   32'(tod / 3600));
        chk({tag, " minutes"}, 32'(minutes), 32'((tod / 60) % 60));
        chk({tag, " seconds"}, 32'(seconds), 32'(tod % 60));
        chk({tag, " mode"},    32'(mode),    32'(mmode));
        chk({tag, " blink"},   32'(blink),   32'(exp_blink));
    endtask

    initial begin
        rst_n    = 1'b0;
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        tod      = 0;
        mmode    = 0;
        phase    = 0;
        age      = 0;
        #12;
        check_all("reset");
        rst_n = 1'b1;

        // 24 single presses wrap hours back to 0, five more give 5
        press_mode(1'b0);
        check_all("enter_set_h");
        for (int i = 0; i < 24; i++) hold_up(1);
        check_all("hours_wrap24");
        for (int i = 0; i < 5; i++) hold_up(1);
        check_all("hours_5");
        press_mode(1'b0);
        for (int i = 0; i < 12; i++) hold_up(1);
        check_all("minutes_12");
        press_mode(1'b0);
        check_all("exit_to_run");
        idle(132);
        check_all("run_05_12_33");
        idle(1);

        // asynchronous reset off a clock edge, mid-count
        #3;
        rst_n = 1'b0;
        #1;
        tod = 0; mmode = 0; phase = 0; age = 0;
        check_all("async_reset");
        #2;
        rst_n = 1'b1;
        idle(3);
        check_all("post_reset_3cyc");
        idle(1);
        check_all("post_reset_tick");

        // set 23:59 through auto-repeat, then roll over midnight
        press_mode(1'b0);
        hold_up(67);
        check_all("hold_to_23");
        press_mode(1'b0);
        hold_up(175);
        check_all("hold_to_59");
        press_mode(1'b0);
        idle(235);
        check_all("run_23_59_59");
        idle(4);
        check_all("midnight");

        // minutes 58 then a 10-cycle hold: 59,0,1,2 with no hour carry
        press_mode(1'b0);
        press_mode(1'b0);
        hold_up(172);
        check_all("minutes_58");
        hold_up(10);
        check_all("hold10_wrap");

        // simultaneous mode and up edges in SET_H: mode change wins
        press_mode(1'b0);
        press_mode(1'b0);
        press_mode(1'b1);
        check_all("mode_wins");

        // seconds freeze in SET_H, cleared on return to RUN, first tick 4 cycles later
        press_mode(1'b0);
        idle(68);
        check_all("run_sec_17");
        press_mode(1'b0);
        hold_up(20);
        check_all("set_h_freeze");
        press_mode(1'b0);
        press_mode(1'b0);
        check_all("exit_sec_clear");
        idle(2);
        check_all("exit_edge3");
        idle(1);
        check_all("exit_edge4");

        // randomized mix of idles, holds and mode presses
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: idle($urandom_range(1, 12));
                1: hold_up($urandom_range(1, 12));
                2: press_mode(1'b0);
                default: press_mode(1'b1);
            endcase
            check_all("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
